// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// load/store op codes, bus size codes and the registered request record.
package mem_access_ctrl_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Combinational request shaping: bus size, byte strobes, lane-replicated
// store data and the alignment check for one load/store op.
module mem_store_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0]  i_alucontrol,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_writedata,
    output logic [1:0]  o_size,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_size       = SIZE_WORD;
        o_wstrb      = 4'b0000;
        o_wdata      = 32'd0;
        o_misaligned = 1'b0;
        case (i_alucontrol)
            EXE_LB_OP, EXE_LBU_OP: begin
                o_size = SIZE_BYTE;
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                o_size       = SIZE_HALF;
                o_misaligned = i_addr[0];
            end
            EXE_LW_OP: begin
                o_size       = SIZE_WORD;
                o_misaligned = |i_addr[1:0];
            end
            EXE_SB_OP: begin
                o_size  = SIZE_BYTE;
                o_wstrb = 4'b0001 << i_addr[1:0];
                o_wdata = {4{i_writedata[7:0]}};
            end
            EXE_SH_OP: begin
                o_size       = SIZE_HALF;
                o_wstrb      = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_writedata[15:0]}};
                o_misaligned = i_addr[0];
            end
            EXE_SW_OP: begin
                o_size       = SIZE_WORD;
                o_wstrb      = 4'b1111;
                o_wdata      = i_writedata;
                o_misaligned = |i_addr[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one bus transaction per
// aligned load/store, stalls until it completes and holds the raw read word.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        memenM,
    input  logic [7:0]  alucontrolM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        flushM,
    input  logic        advanceM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic [31:0] badvaddrM
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    mem_req_t    r_req;
    logic        r_is_load;
    logic [31:0] r_readdata;

    logic [1:0]  w_size;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic        w_misaligned;
    logic        w_is_store;
    logic        w_issue;

    mem_store_align u_store_align (
        .i_alucontrol (alucontrolM),
        .i_addr       (aluoutM),
        .i_writedata  (writedataM),
        .o_size       (w_size),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned)
    );

    assign w_is_store = is_store_op(alucontrolM);
    assign w_issue    = (r_state == ST_IDLE) & memenM & ~w_misaligned & ~flushM;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue)
                    w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (data_addr_ok)
                    w_state_next = ST_WAIT;
                else if (flushM)
                    w_state_next = ST_IDLE;
            end
            ST_WAIT: begin
                // A response arriving together with a flush still completes.
                if (data_data_ok)
                    w_state_next = ST_DONE;
                else if (flushM)
                    w_state_next = ST_DRAIN;
            end
            ST_DONE: begin
                if (advanceM || flushM)
                    w_state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_data_ok)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req     <= '0;
            r_is_load <= 1'b0;
        end else if (w_issue) begin
            r_req     <= '{wr: w_is_store, size: w_size, addr: aluoutM,
                           wdata: w_wdata, wstrb: w_wstrb};
            r_is_load <= ~w_is_store;
        end
    end

    // Only a live load's response is kept; drained responses never land here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_readdata <= 32'd0;
        else if ((r_state == ST_WAIT) && data_data_ok && r_is_load)
            r_readdata <= data_rdata;
    end

    assign data_req   = (r_state == ST_REQ);
    assign data_wr    = r_req.wr;
    assign data_size  = r_req.size;
    assign data_addr  = r_req.addr;
    assign data_wdata = r_req.wdata;
    assign data_wstrb = r_req.wstrb;
    assign readdataM  = r_readdata;

    assign stallM = resetn & (w_issue | (r_state == ST_REQ) |
                              (r_state == ST_WAIT) | (r_state == ST_DRAIN));
    assign adelM  = resetn & memenM & w_misaligned & ~w_is_store;
    assign adesM  = resetn & memenM & w_misaligned & w_is_store;
    assign badvaddrM = (adelM | adesM) ? aluoutM : 32'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a latency-programmable bus model
// answers requests while scenario tasks score requests and read data.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        memenM;
    logic [7:0]  alucontrolM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        advanceM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] readdataM;
    logic        stallM;
    logic        adelM;
    logic        adesM;
    logic [31:0] badvaddrM;

    int checks = 0;
    int errors = 0;
    int a_lat = 0;
    int d_lat = 1;
    logic [31:0] rd_val = 32'd0;
    logic [31:0] model_rd = 32'd0;
    mem_req_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .resetn(resetn), .memenM(memenM), .alucontrolM(alucontrolM),
        .aluoutM(aluoutM), .writedataM(writedataM), .flushM(flushM), .advanceM(advanceM),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .readdataM(readdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM),
        .badvaddrM(badvaddrM)
    );

    // Bus slave: addr_ok after a_lat waiting cycles, data_ok d_lat cycles after accept.
    initial begin : bus_model
        int  a_cnt;
        int  d_cnt;
        bit  in_req;
        bit  in_data;
        a_cnt = 0; d_cnt = 0; in_req = 0; in_data = 0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            if (!resetn) begin
                in_req = 0; in_data = 0;
            end else if (in_data) begin
                if (d_cnt <= 1) begin
                    data_data_ok = 1'b1; data_rdata = rd_val; in_data = 0;
                end else d_cnt--;
            end else if (data_req) begin
                if (!in_req) begin in_req = 1; a_cnt = a_lat; end
                if (a_cnt == 0) begin
                    data_addr_ok = 1'b1; in_req = 0; in_data = 1; d_cnt = d_lat;
                end else a_cnt--;
            end else in_req = 0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    function automatic mem_req_t mk_req(input logic wr, input logic [1:0] sz,
                                        input logic [31:0] a, input logic [31:0] wd,
                                        input logic [3:0] st);
        mem_req_t r;
        r.wr = wr; r.size = sz; r.addr = a; r.wdata = wd; r.wstrb = st;
        return r;
    endfunction

    task automatic drive_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
        memenM = 1'b1; alucontrolM = op; aluoutM = addr; writedataM = wd;
    endtask

    task automatic finish_access;
        @(posedge clk); #1;
        advanceM = 1'b1;
        @(posedge clk); #1;
        advanceM = 1'b0; memenM = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; memenM = 1'b0; alucontrolM = 8'd0; aluoutM = 32'd0;
        writedataM = 32'd0; flushM = 1'b0; advanceM = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, readdataM,
             stallM, adelM, adesM, badvaddrM} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b stall=%b addr=%h rd=%h, want all zero",
                     data_req, stallM, data_addr, readdataM);
        end
        drive_op(EXE_LW_OP, 32'h0000_1001, 32'd0);
        @(negedge clk);
        checks++;
        if ({stallM, adelM, adesM, badvaddrM, data_req} !== '0) begin
            errors++;
            $display("FAIL reset_gated: got stall=%b adel=%b badv=%h, want 0 0 0",
                     stallM, adelM, badvaddrM);
        end
        @(posedge clk); #1;
        memenM = 1'b0; resetn = 1'b1;
        model_rd = 32'd0;
        $display("txn reset done");
    endtask

    task automatic run_access(input string nm, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input int al, input int dl,
                              input logic [31:0] rd, input bit ld, input mem_req_t e,
                              input int hold);
        int stall_n; int reqs; bit done; mem_req_t g; logic [31:0] exp_rd;
        a_lat = al; d_lat = dl; rd_val = rd;
        exp_rd = ld ? rd : model_rd;
        exp_q.push_back(e);
        @(posedge clk); #1;
        flushM = 1'b0; advanceM = 1'b0;
        drive_op(op, addr, wd);
        stall_n = 0; reqs = 0; done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (data_req && data_addr_ok) begin
                reqs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_req: got addr=%h, want no request", nm, data_addr);
                end else begin
                    g = exp_q.pop_front();
                    if (data_wr !== g.wr || data_size !== g.size || data_addr !== g.addr ||
                        data_wstrb !== g.wstrb || (g.wr && data_wdata !== g.wdata)) begin
                        errors++;
                        $display("FAIL %s req: got wr=%b size=%0d addr=%h wdata=%h wstrb=%b, want wr=%b size=%0d addr=%h wdata=%h wstrb=%b",
                                 nm, data_wr, data_size, data_addr, data_wdata, data_wstrb,
                                 g.wr, g.size, g.addr, g.wdata, g.wstrb);
                    end
                end
            end
            if (stallM) stall_n++; else done = 1;
        end
        checks++;
        if (!done || stall_n != 2 + al + dl || reqs != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s handshake: got done=%0d stalls=%0d reqs=%0d pending=%0d, want 1 %0d 1 0",
                     nm, done, stall_n, reqs, exp_q.size(), 2 + al + dl);
        end
        checks++;
        if (readdataM !== exp_rd) begin
            errors++;
            $display("FAIL %s readdata: got %h, want %h", nm, readdataM, exp_rd);
        end
        if (ld) model_rd = rd;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (stallM !== 1'b0 || data_req !== 1'b0 || readdataM !== exp_rd) begin
                errors++;
                $display("FAIL %s done_hold: got stall=%b req=%b rd=%h, want 0 0 %h",
                         nm, stallM, data_req, readdataM, exp_rd);
            end
        end
        finish_access();
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0 || stallM !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: got req=%b stall=%b, want 0 0", nm, data_req, stallM);
        end
        $display("txn %s addr=%h stalls=%0d readdata=%h", nm, addr, stall_n, readdataM);
    endtask

    task automatic test_misaligned;
        @(posedge clk); #1;
        drive_op(EXE_LH_OP, 32'h0000_3001, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({adelM, adesM, badvaddrM, stallM, data_req} !== {1'b1, 1'b0, 32'h0000_3001, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL misaligned_lh: got adel=%b ades=%b badv=%h stall=%b req=%b, want 1 0 00003001 0 0",
                         adelM, adesM, badvaddrM, stallM, data_req);
            end
        end
        @(posedge clk); #1;
        drive_op(EXE_SW_OP, 32'h0000_3002, 32'h1111_2222);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({adelM, adesM, badvaddrM, stallM, data_req} !== {1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL misaligned_sw: got adel=%b ades=%b badv=%h stall=%b req=%b, want 0 1 00003002 0 0",
                         adelM, adesM, badvaddrM, stallM, data_req);
            end
        end
        @(posedge clk); #1;
        memenM = 1'b0;
        @(negedge clk);
        checks++;
        if ({adelM, adesM} !== 2'b00) begin
            errors++;
            $display("FAIL misaligned_clear: got adel=%b ades=%b, want 0 0", adelM, adesM);
        end
        $display("txn misaligned LH/SW reported");
    endtask

    task automatic test_flush_req;
        a_lat = 3; d_lat = 1;
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h0000_1300, 32'd0);
        @(posedge clk); #1;
        flushM = 1'b1; memenM = 1'b0;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b1 || data_addr !== 32'h0000_1300) begin
            errors++;
            $display("FAIL flush_req_issue: got req=%b addr=%h, want 1 00001300", data_req, data_addr);
        end
        @(posedge clk); #1;
        flushM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (data_req !== 1'b0 || stallM !== 1'b0) begin
                errors++;
                $display("FAIL flush_req_withdrawn: got req=%b stall=%b, want 0 0", data_req, stallM);
            end
        end
        $display("txn flush in REQ withdrawn");
    endtask

    task automatic test_flush_wait;
        mem_req_t g; bit done; int reqs;
        a_lat = 0; d_lat = 5; rd_val = 32'hBADB_AD00;
        exp_q.push_back(mk_req(1'b0, SIZE_WORD, 32'h0000_1100, 32'd0, 4'b0000));
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h0000_1100, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (!(data_req && data_addr_ok) || exp_q.size() == 0) begin
            errors++;
            $display("FAIL flush_wait_accept: got req=%b addr_ok=%b, want 1 1", data_req, data_addr_ok);
        end else begin
            g = exp_q.pop_front();
            if (data_addr !== g.addr || data_wr !== g.wr) begin
                errors++;
                $display("FAIL flush_wait_accept: got addr=%h wr=%b, want %h %b", data_addr, data_wr, g.addr, g.wr);
            end
        end
        @(posedge clk); #1;
        flushM = 1'b1; memenM = 1'b0;
        @(posedge clk); #1;
        flushM = 1'b0;
        exp_q.push_back(mk_req(1'b0, SIZE_WORD, 32'h0000_1200, 32'd0, 4'b0000));
        drive_op(EXE_LW_OP, 32'h0000_1200, 32'd0);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            checks++;
            if (stallM !== 1'b1 || data_req !== 1'b0 || readdataM !== model_rd) begin
                errors++;
                $display("FAIL flush_wait_drain: got stall=%b req=%b rd=%h, want 1 0 %h",
                         stallM, data_req, readdataM, model_rd);
            end
            if (data_data_ok) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL flush_wait_drain_end: got no data_ok, want data_ok within 20 cycles");
        end
        rd_val = 32'h0BAD_F00D; d_lat = 1;
        done = 0; reqs = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (data_req && data_addr_ok) begin
                reqs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL flush_wait_reissue: got extra req addr=%h, want none", data_addr);
                end else begin
                    g = exp_q.pop_front();
                    if (data_addr !== g.addr || data_wr !== g.wr || data_size !== g.size) begin
                        errors++;
                        $display("FAIL flush_wait_reissue: got addr=%h wr=%b size=%0d, want %h %b %0d",
                                 data_addr, data_wr, data_size, g.addr, g.wr, g.size);
                    end
                end
            end
            if (!stallM) done = 1;
        end
        checks++;
        if (!done || reqs != 1 || readdataM !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL flush_wait_next_load: got done=%0d reqs=%0d rd=%h, want 1 1 0badf00d",
                     done, reqs, readdataM);
        end
        model_rd = 32'h0BAD_F00D;
        finish_access();
        $display("txn flush in WAIT drained, next load rd=%h", readdataM);
    endtask

    task automatic test_flush_dataok;
        mem_req_t g;
        a_lat = 0; d_lat = 1; rd_val = 32'h5555_AAAA;
        exp_q.push_back(mk_req(1'b0, SIZE_WORD, 32'h0000_1400, 32'd0, 4'b0000));
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h0000_1400, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (!(data_req && data_addr_ok) || exp_q.size() == 0) begin
            errors++;
            $display("FAIL flush_dataok_accept: got req=%b addr_ok=%b, want 1 1", data_req, data_addr_ok);
        end else begin
            g = exp_q.pop_front();
            if (data_addr !== g.addr) begin
                errors++;
                $display("FAIL flush_dataok_accept: got addr=%h, want %h", data_addr, g.addr);
            end
        end
        @(posedge clk); #1;
        flushM = 1'b1; memenM = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (stallM !== 1'b0 || readdataM !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL flush_dataok_done: got stall=%b rd=%h, want 0 5555aaaa", stallM, readdataM);
        end
        model_rd = 32'h5555_AAAA;
        @(posedge clk); #1;
        flushM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (data_req !== 1'b0 || stallM !== 1'b0 || readdataM !== model_rd) begin
                errors++;
                $display("FAIL flush_dataok_idle: got req=%b stall=%b rd=%h, want 0 0 %h",
                         data_req, stallM, readdataM, model_rd);
            end
        end
        $display("txn flush with data_ok completed rd=%h", readdataM);
    endtask

    task automatic test_reset_wait;
        mem_req_t g;
        a_lat = 0; d_lat = 10; rd_val = 32'h7777_7777;
        exp_q.push_back(mk_req(1'b0, SIZE_WORD, 32'h0000_1500, 32'd0, 4'b0000));
        @(posedge clk); #1;
        drive_op(EXE_LW_OP, 32'h0000_1500, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        if (data_req && data_addr_ok && exp_q.size() != 0) g = exp_q.pop_front();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_wait_accept: got pending=%0d, want 0", exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (stallM !== 1'b1) begin
            errors++;
            $display("FAIL reset_wait_stall: got %b, want 1", stallM);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({data_req, data_wr, data_size, data_addr, data_wstrb, readdataM, stallM} !== '0) begin
            errors++;
            $display("FAIL reset_wait_clear: got req=%b stall=%b addr=%h rd=%h, want all zero",
                     data_req, stallM, data_addr, readdataM);
        end
        model_rd = 32'd0;
        @(posedge clk); #1;
        memenM = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (data_req !== 1'b0 || stallM !== 1'b0 || readdataM !== model_rd) begin
                errors++;
                $display("FAIL reset_wait_after: got req=%b stall=%b rd=%h, want 0 0 %h",
                         data_req, stallM, readdataM, model_rd);
            end
        end
        $display("txn reset during WAIT recovered");
    endtask

    initial begin
        test_reset();
        run_access("LW", EXE_LW_OP, 32'h0000_1000, 32'd0, 2, 3, 32'hDEAD_BEEF, 1'b1,
                   mk_req(1'b0, SIZE_WORD, 32'h0000_1000, 32'd0, 4'b0000), 3);
        run_access("SB", EXE_SB_OP, 32'h0000_2003, 32'h0000_00A5, 0, 1, 32'd0, 1'b0,
                   mk_req(1'b1, SIZE_BYTE, 32'h0000_2003, 32'hA5A5_A5A5, 4'b1000), 0);
        run_access("SH", EXE_SH_OP, 32'h0000_2002, 32'h0000_1234, 1, 2, 32'd0, 1'b0,
                   mk_req(1'b1, SIZE_HALF, 32'h0000_2002, 32'h1234_1234, 4'b1100), 0);
        run_access("SW", EXE_SW_OP, 32'h0000_2004, 32'hCAFE_F00D, 0, 1, 32'd0, 1'b0,
                   mk_req(1'b1, SIZE_WORD, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111), 1);
        run_access("LBU", EXE_LBU_OP, 32'h0000_1003, 32'd0, 0, 1, 32'h1122_3344, 1'b1,
                   mk_req(1'b0, SIZE_BYTE, 32'h0000_1003, 32'd0, 4'b0000), 0);
        test_misaligned();
        test_flush_req();
        test_flush_wait();
        test_flush_dataok();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage data-memory access controller for the five-stage MIPS pipeline. It turns a load/store in MEM into one SRAM-like bus transaction and checks address alignment. It builds size, byte strobes and replicated store data, stalls the pipeline until the bus answers, and holds the raw 32-bit read word. That word goes to the writeback load-data selector, which performs byte/half extraction and sign/zero extension.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  pipeline clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- memenM  in  1  MEM-stage instruction is a load or store
- alucontrolM  in  8  op code; uses EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP from defines.vh
- aluoutM  in  32  effective address
- writedataM  in  32  store source register value
- flushM  in  1  pipeline flush (exception/eret) this cycle
- advanceM  in  1  MEM->WB register loads this cycle
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  request address
- data_wdata  out  32  replicated store data
- data_wstrb  out  4  byte enables; 0000 for loads
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete; never in the same cycle as its own addr_ok
- data_rdata  in  32  read word
- readdataM  out  32  captured read word, feeds the WB selector
- stallM  out  1  freeze IF..MEM
- adelM, adesM  out  1  load / store address error
- badvaddrM  out  32  faulting address

## Operation
- Alignment: LW/SW need addr[1:0]=00. LH/LHU/SH need addr[0]=0. Byte ops are always aligned.
- Misaligned access: raise adelM (load) or adesM (store) combinationally and set badvaddrM = aluoutM. Issue no request and keep stallM=0.
- Strobes:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{wd[7:0]}}.
  - SH: wstrb = 0011 (addr[1]=0) or 1100, wdata = {2{wd[15:0]}}.
  - SW: wstrb = 1111.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE -> REQ when memenM & aligned & !flushM. data_* fields are registered at this edge.
  - REQ: data_req=1. On addr_ok go to WAIT. On flushM without addr_ok go to IDLE; the request is withdrawn.
  - WAIT: on data_ok go to DONE and capture rdata into readdataM (loads only). On flushM go to DRAIN.
  - DONE: on advanceM or flushM go to IDLE.
  - DRAIN: on data_ok go to IDLE; the response is discarded and readdataM is unchanged.
- stallM = (IDLE & memenM & aligned & !flushM) | REQ | WAIT | DRAIN. stallM=0 in DONE.
- Every transaction is issued exactly once: at most one outstanding, and no re-issue after DONE.
- data_req is low in every state except REQ.

## Timing
- Reset (asynchronous, resetn=0): state IDLE. All outputs are 0: data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, readdataM, stallM, adelM, adesM, badvaddrM.
- Fastest access sequence:
  - cycle 0: IDLE with access, stallM=1.
  - cycle 1: REQ, addr_ok=1.
  - cycle 2: WAIT, data_ok=1.
  - cycle 3: DONE, stallM=0.
  - Minimum penalty is 3 stall cycles.
- readdataM is valid from the first DONE cycle. It is held until the next captured load.
- data_* outputs are stable from entry to REQ until addr_ok.
- flushM and data_ok in the same WAIT cycle: data_ok wins. Go to DONE, then to IDLE on the flush.
- Reset during WAIT/DRAIN returns to IDLE. The bus side is reset by the same resetn.

## Structure
- Op codes come from defines.vh. Add size codes SIZE_BYTE/HALF/WORD to defines.vh.
- The FSM state encoding is local to the module.
- Sub-module mem_store_align (combinational): alucontrol, addr, writedata -> size, wstrb, wdata, misaligned flag.

## Test plan
- LW addr 0x1000, addr_ok after 2 cycles, data_ok 3 cycles later with 0xDEADBEEF -> one req, readdataM=0xDEADBEEF, stallM high exactly until DONE.
- SB addr 0x2003, wd 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5, size 0, wr 1.
- SH addr 0x2002, wd 0x1234 -> wstrb 1100, wdata 0x12341234.
- LH addr 0x3001 -> adelM=1, badvaddrM=0x3001, data_req never asserted, stallM=0. SW addr 0x3002 -> adesM=1.
- flushM in WAIT, data_ok 4 cycles later -> DRAIN, stallM held, readdataM unchanged, next LW issues only after the drain.
- DONE with advanceM=0 for 3 cycles -> no second request, readdataM stable; advanceM=1 -> IDLE.
